// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_pkg
//  Purpose  : Shared constants and types for the TMDS DDR sequencer.
//             Holds the TMDS control symbols, the clock-channel pattern,
//             the symbol/phase geometry and the sequencer state type.
//  Revision : 1.0  initial release
// ============================================================================
package tmds_pkg;

  // Symbol geometry: 10 bits per symbol, 2 bits per shift cycle -> 5 phases.
  localparam int SYM_W  = 10;
  localparam int PHASES = 5;

  // Last phase of a symbol period; loads and stops happen here.
  localparam logic [2:0] PHASE_LAST = 3'(PHASES - 1);

  // TMDS control-period symbols, indexed by {C1,C0}.
  localparam logic [SYM_W-1:0] TMDS_CTL0 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TMDS_CTL1 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TMDS_CTL2 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TMDS_CTL3 = 10'b1010101011;

  // Pixel-clock pattern on the clock channel, LSB first: 5 ones, 5 zeros.
  localparam logic [SYM_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

  // Sequencer state.
  typedef enum logic [0:0] {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } seq_state_t;

endpackage : tmds_pkg
`default_nettype wire

// File: rtl/tmds_shift2.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_shift2
//  Purpose  : 10-bit symbol register that emits 2 bits per cycle.
//             Loads a full symbol, shifts right by 2 with zero fill, or
//             clears. The current DDR pair is always the two LSBs.
//  Ports    : clk       - shift clock
//             resetn    - synchronous active-low reset (register -> 0)
//             i_load    - load i_data (wins over shift)
//             i_shift   - shift right by 2, zero fill
//             i_clear   - clear register (wins over load and shift)
//             i_data    - symbol to load
//             o_pair    - current DDR pair, [0]=first half, [1]=second half
//  Revision : 1.0  initial release
// ============================================================================
module tmds_shift2
  import tmds_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic [SYM_W-1:0] i_data,
  output logic [1:0]       o_pair
);

  logic [SYM_W-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sh <= '0;
    end else if (i_clear) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {2'b00, r_sh[SYM_W-1:2]};
    end
  end

  // Straight from the register: no path from i_data to o_pair.
  assign o_pair = r_sh[1:0];

endmodule : tmds_shift2
`default_nettype wire

// File: rtl/tmds_ddr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_ddr_sequencer
//  Purpose  : Serializes 10-bit TMDS symbols for red/green/blue plus a
//             generated pixel-clock pattern into 2-bit DDR pairs, one
//             symbol per channel every 5 shift-clock cycles.
//  Ports    : clk_shift  - shift clock (5x pixel clock), the only clock
//             resetn     - synchronous active-low reset
//             enable     - run request, honoured only at symbol boundaries
//             sym_valid  - upstream symbol triple valid
//             sym_red/green/blue - TMDS symbols, LSB transmitted first
//             sym_ready  - combinational accept strobe (load cycles only)
//             out_clock/red/green/blue - DDR pairs, [0]=D0, [1]=D1
//             active     - high while running
//             uflow_cnt  - saturating count of substituted idle symbols
//             uflow_clr  - synchronous clear of uflow_cnt
//  Revision : 1.0  initial release
// ============================================================================
module tmds_ddr_sequencer
  import tmds_pkg::*;
#(
  parameter logic [SYM_W-1:0] IDLE_SYMBOL = TMDS_CTL0,
  parameter logic [SYM_W-1:0] CLK_PATTERN = TMDS_CLK_PATTERN,
  parameter int               UFLOW_W     = 16
) (
  input  logic               clk_shift,
  input  logic               resetn,
  input  logic               enable,
  input  logic               sym_valid,
  input  logic [SYM_W-1:0]   sym_red,
  input  logic [SYM_W-1:0]   sym_green,
  input  logic [SYM_W-1:0]   sym_blue,
  output logic               sym_ready,
  output logic [1:0]         out_clock,
  output logic [1:0]         out_red,
  output logic [1:0]         out_green,
  output logic [1:0]         out_blue,
  output logic               active,
  output logic [UFLOW_W-1:0] uflow_cnt,
  input  logic               uflow_clr
);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [2:0]         r_phase;
  logic [2:0]         w_phase_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_clear;
  logic               w_uflow_inc;
  logic [UFLOW_W-1:0] r_uflow_cnt;
  logic [SYM_W-1:0]   w_red_d;
  logic [SYM_W-1:0]   w_green_d;
  logic [SYM_W-1:0]   w_blue_d;

  // --------------------------------------------------------------------------
  // State / phase register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_shift) begin
    if (!resetn) begin
      r_state <= ST_OFF;
      r_phase <= PHASE_LAST;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and shift-register controls.
  // OFF parks the phase at the last slot, so OFF+enable is simply an ordinary
  // boundary load and start-up needs no special case.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clear     = 1'b0;

    case (r_state)
      ST_OFF: begin
        w_phase_nxt = PHASE_LAST;
        if (enable) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
          w_phase_nxt = 3'd0;
        end
      end

      ST_RUN: begin
        if (r_phase != PHASE_LAST) begin
          // Mid-symbol: enable is ignored, the symbol always completes.
          w_shift     = 1'b1;
          w_phase_nxt = r_phase + 3'd1;
        end else if (enable) begin
          w_load      = 1'b1;
          w_phase_nxt = 3'd0;
        end else begin
          w_clear     = 1'b1;
          w_state_nxt = ST_OFF;
          w_phase_nxt = PHASE_LAST;
        end
      end

      default: begin
        w_state_nxt = ST_OFF;
        w_phase_nxt = PHASE_LAST;
      end
    endcase
  end

  // The handshake accepts exactly on load cycles.
  assign sym_ready   = w_load;
  assign w_uflow_inc = w_load & ~sym_valid;

  // Substitute the idle control symbol when upstream has nothing to offer.
  assign w_red_d   = sym_valid ? sym_red   : IDLE_SYMBOL;
  assign w_green_d = sym_valid ? sym_green : IDLE_SYMBOL;
  assign w_blue_d  = sym_valid ? sym_blue  : IDLE_SYMBOL;

  // --------------------------------------------------------------------------
  // Underflow counter. A clear coinciding with an underflow leaves 1: the
  // clear is applied first, then the new event is counted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_shift) begin
    if (!resetn) begin
      r_uflow_cnt <= '0;
    end else if (uflow_clr) begin
      r_uflow_cnt <= UFLOW_W'(w_uflow_inc);
    end else if (w_uflow_inc && (r_uflow_cnt != {UFLOW_W{1'b1}})) begin
      r_uflow_cnt <= r_uflow_cnt + UFLOW_W'(1);
    end
  end

  assign uflow_cnt = r_uflow_cnt;
  assign active    = (r_state == ST_RUN);

  // --------------------------------------------------------------------------
  // Per-channel serializers
  // --------------------------------------------------------------------------
  tmds_shift2 u_sh_clock (
    .clk     (clk_shift),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (CLK_PATTERN),
    .o_pair  (out_clock)
  );

  tmds_shift2 u_sh_red (
    .clk     (clk_shift),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (w_red_d),
    .o_pair  (out_red)
  );

  tmds_shift2 u_sh_green (
    .clk     (clk_shift),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (w_green_d),
    .o_pair  (out_green)
  );

  tmds_shift2 u_sh_blue (
    .clk     (clk_shift),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (w_blue_d),
    .o_pair  (out_blue)
  );

endmodule : tmds_ddr_sequencer
`default_nettype wire

// File: tb/tb_tmds_ddr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_ddr_sequencer
//  Purpose  : Self-checking bench for tmds_ddr_sequencer. A queue-based
//             model turns each accepted (or substituted) symbol into five
//             expected DDR pairs; a new symbol starts when the previous
//             one's pairs are used up.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmds_ddr_sequencer;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] CLKP = 10'b0000011111;

  logic       clk_shift = 1'b0;
  logic       resetn, enable, sym_valid, uflow_clr;
  logic [9:0] sym_red, sym_green, sym_blue;
  logic       sym_ready, active;
  logic [1:0] out_clock, out_red, out_green, out_blue;
  logic [15:0] uflow_cnt;
  // Second instance with a 2-bit counter for the saturation boundary.
  logic       s_ready, s_active;
  logic [1:0] s_clock, s_red, s_green, s_blue;
  logic [1:0] s_uflow;

  int n_pass  = 0;
  int n_total = 0;

  // Model state
  logic [1:0] q_r[$], q_g[$], q_b[$], q_c[$];
  logic [1:0] e_r, e_g, e_b, e_c;
  logic       e_active;
  int         e_uflow;
  logic       e_ready;
  int         valid_pct;

  always #5 clk_shift = ~clk_shift;

  tmds_ddr_sequencer dut (
    .clk_shift(clk_shift), .resetn(resetn), .enable(enable),
    .sym_valid(sym_valid), .sym_red(sym_red), .sym_green(sym_green),
    .sym_blue(sym_blue), .sym_ready(sym_ready), .out_clock(out_clock),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .active(active), .uflow_cnt(uflow_cnt), .uflow_clr(uflow_clr)
  );

  tmds_ddr_sequencer #(.UFLOW_W(2)) dut_w2 (
    .clk_shift(clk_shift), .resetn(resetn), .enable(enable),
    .sym_valid(sym_valid), .sym_red(sym_red), .sym_green(sym_green),
    .sym_blue(sym_blue), .sym_ready(s_ready), .out_clock(s_clock),
    .out_red(s_red), .out_green(s_green), .out_blue(s_blue),
    .active(s_active), .uflow_cnt(s_uflow), .uflow_clr(uflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Five pairs of a symbol, LSB pair first.
  task automatic push_sym(input logic [9:0] r, input logic [9:0] g,
                          input logic [9:0] b);
    logic [9:0] tr, tg, tb, tc;
    for (int k = 0; k < 5; k++) begin
      tr = r >> (2 * k); tg = g >> (2 * k); tb = b >> (2 * k); tc = CLKP >> (2 * k);
      q_r.push_back(tr[1:0]); q_g.push_back(tg[1:0]);
      q_b.push_back(tb[1:0]); q_c.push_back(tc[1:0]);
    end
  endtask

  // Model update for one rising edge, using the inputs held across it.
  task automatic model_edge();
    logic under;
    under = 1'b0;
    if (!resetn) begin
      q_r.delete(); q_g.delete(); q_b.delete(); q_c.delete();
      e_r = 2'b00; e_g = 2'b00; e_b = 2'b00; e_c = 2'b00;
      e_active = 1'b0;
      e_uflow  = 0;
    end else begin
      if (q_c.size() == 0) begin
        if (enable) begin
          under = !sym_valid;
          if (sym_valid) push_sym(sym_red, sym_green, sym_blue);
          else           push_sym(IDLE, IDLE, IDLE);
          e_active = 1'b1;
        end else begin
          e_active = 1'b0;
        end
      end
      if (q_c.size() > 0) begin
        e_r = q_r.pop_front(); e_g = q_g.pop_front();
        e_b = q_b.pop_front(); e_c = q_c.pop_front();
      end else begin
        e_r = 2'b00; e_g = 2'b00; e_b = 2'b00; e_c = 2'b00;
      end
      if (uflow_clr)  e_uflow = under ? 1 : 0;
      else if (under) e_uflow++;
    end
  endtask

  // One clock cycle; entered and left at a falling edge with inputs set.
  task automatic cycle(output logic acc);
    e_ready = resetn && enable && (q_c.size() == 0);
    acc     = e_ready && sym_valid;
    #1;
    if (resetn) check("sym_ready", sym_ready, e_ready);
    @(posedge clk_shift);
    model_edge();
    @(negedge clk_shift);
    check("out_red",   out_red,   e_r);
    check("out_green", out_green, e_g);
    check("out_blue",  out_blue,  e_b);
    check("out_clock", out_clock, e_c);
    check("active",    active,    e_active);
    check("uflow_cnt", uflow_cnt, (e_uflow > 65535) ? 65535 : e_uflow);
    check("uflow_w2",  s_uflow,   (e_uflow > 3) ? 3 : e_uflow);
  endtask

  // mode 0: hold data; 1: invert blue on accept; 2: fully random traffic
  task automatic run(input int n, input int mode);
    logic acc;
    for (int i = 0; i < n; i++) begin
      if (mode == 2) begin
        if ($urandom_range(0, 99) < 10) enable = ~enable;
        uflow_clr = ($urandom_range(0, 99) < 3);
        resetn    = ($urandom_range(0, 99) >= 2);
      end
      cycle(acc);
      if (mode == 1 && acc) sym_blue = ~sym_blue;
      if (mode == 2) begin
        if (acc || !sym_valid) begin
          sym_red   = 10'($urandom);
          sym_green = 10'($urandom);
          sym_blue  = 10'($urandom);
          sym_valid = ($urandom_range(0, 99) < valid_pct);
        end
        uflow_clr = 1'b0;
        resetn    = 1'b1;
      end
    end
  endtask

  initial begin
    int npulse;
    logic acc;
    resetn = 1'b0; enable = 1'b0; sym_valid = 1'b0; uflow_clr = 1'b0;
    sym_red = '0; sym_green = '0; sym_blue = '0;
    valid_pct = 70;
    e_r = 2'b00; e_g = 2'b00; e_b = 2'b00; e_c = 2'b00;
    e_active = 1'b0; e_uflow = 0;

    // Reset, then idle in OFF.
    @(negedge clk_shift);
    run(3, 0);
    resetn = 1'b1;
    run(4, 0);

    // Held symbol; ready pulses once per 5 cycles.
    enable = 1'b1; sym_valid = 1'b1;
    sym_red = 10'b1010011100; sym_green = 10'($urandom); sym_blue = 10'($urandom);
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      #1; if (sym_ready) npulse++;
      #0;
      cycle(acc);
    end
    check("ready_pulses", npulse, 3);

    // Back-to-back blue 3FF then 000.
    sym_blue = 10'h3FF;
    run(10, 1);

    // Three underflow slots.
    sym_valid = 1'b0;
    run(15, 0);
    check("uflow_after3", uflow_cnt, 3);

    // Clear coinciding with an underflow load.
    uflow_clr = 1'b1;
    run(1, 0);
    uflow_clr = 1'b0;
    check("uflow_clr_same", uflow_cnt, 1);
    run(4, 0);

    // Six more underflows saturate the 2-bit counter.
    run(30, 0);
    check("uflow_w2_sat", s_uflow, 3);

    // Drop enable at phase 1; the symbol completes then outputs go quiet.
    sym_valid = 1'b1;
    run(2, 0);
    enable = 1'b0;
    run(10, 0);
    check("off_active", active, 0);

    // Reset mid-symbol at phase 2, enable held high.
    enable = 1'b1;
    run(3, 0);
    resetn = 1'b0;
    run(1, 0);
    resetn = 1'b1;
    run(7, 0);

    // Randomized traffic.
    sym_valid = 1'b1;
    run(400, 2);
    valid_pct = 30;
    run(200, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_tmds_ddr_sequencer
`default_nettype wire

// File: doc/tmds_ddr_sequencer.md
Name: tmds_ddr_sequencer

Overview:
- Sequences 10-bit TMDS symbols (red, green, blue, plus generated pixel-clock pattern) into 2-bit-per-cycle DDR pairs for the fake-differential ODDRX1F output stage.
- Runs entirely in the shift clock domain (5x pixel clock); one symbol per channel every 5 cycles.
- Upstream symbol source is paced by a valid/ready handshake.
- Handles enable/disable at symbol boundaries and substitutes a blanking symbol on underflow, with a status counter.

Parameters:
- IDLE_SYMBOL, 10'b1101010100, TMDS control symbol (CTL=00) sent on all data channels when no symbol is available.
- CLK_PATTERN, 10'b0000011111, pattern loaded on the clock channel each symbol period (LSB first).
- UFLOW_W, 16, width of the saturating underflow counter.

Ports:
- clk_shift  in  1  shift clock, 5x pixel clock; the only clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  request to run the serializer; sampled only at phase 4 or in OFF.
- sym_valid  in  1  upstream symbol triple valid.
- sym_red, sym_green, sym_blue  in  10 each  TMDS symbols, LSB transmitted first.
- sym_ready  out  1  combinational; accept strobe for the current cycle.
- out_clock, out_red, out_green, out_blue  out  2 each  DDR pairs; [0]=D0 (first half), [1]=D1.
  - Wire directly to in_clock/in_red/in_green/in_blue of the fake-differential stage.
- active  out  1  high while state is RUN.
- uflow_cnt  out  UFLOW_W  saturating count of substituted IDLE symbols.
- uflow_clr  in  1  synchronous clear of uflow_cnt.

Behaviour:
- Reset (resetn=0 at rising edge):
  - state=OFF, phase=4, all shift registers=0.
  - All out_* = 2'b00, active=0, uflow_cnt=0.
- State and counters:
  - States: OFF, RUN.
  - phase is a 3-bit counter 0..4, wrapping 4 -> 0 in RUN. It is held at 4 in OFF.
  - Each channel has a 10-bit shift register. out_* = shreg[1:0], taken directly from the registers.
  - In RUN, phase 0..3: each shreg shifts right by 2 (zero-fill); phase increments.
- Load cycle (phase==4 and enable==1, in either state):
  - sym_ready=1.
  - Clock shreg <= CLK_PATTERN.
  - If sym_valid: data shregs <= sym_*.
  - Else: data shregs <= IDLE_SYMBOL, and uflow_cnt increments (saturates at all-ones).
  - state <= RUN, phase <= 0.
- Bit timing:
  - A symbol accepted at edge T appears as bits[1:0] in cycle T+1, bits[3:2] in T+2, ... bits[9:8] in T+5.
  - The next load is at edge T+5, so there are no gaps.
- Disable:
  - RUN, phase==4, enable==0: sym_ready=0, all shregs <= 0, state <= OFF.
  - The symbol in flight always completes; enable is ignored at phases 0..3.
- OFF with enable==0: sym_ready=0, outputs stay 00, no underflow counting.
- sym_ready is never asserted outside a load cycle. sym_valid may be held asserted; data must stay stable until accepted.
- uflow_clr and a same-cycle underflow: the clear applies first, so the result is 1.
- uflow_clr is effective in any state.
- Reset asserted mid-symbol: the next cycle is the reset state, and the partial symbol is discarded.
- No combinational path exists from sym_* to out_*.

Decomposition:
- Shared package tmds_pkg holds:
  - TMDS_CTL0..CTL3 symbol constants (IDLE_SYMBOL default = CTL0).
  - CLK_PATTERN constant.
  - SYM_W=10, PHASES=5.
- One sub-module is natural: tmds_shift2 (10-bit load/shift-by-2 register with load, shift and clear controls), instantiated 4x.
- Phase counter, FSM and underflow counter stay in the top module.

Test Plan:
- Reset then enable=1, sym_valid=1, red=10'b1010011100 held:
  - sym_ready pulses every 5 cycles.
  - out_red over cycles T+1..T+5 = 00, 11, 01, 10, 10.
  - out_clock = 11, 11, 01, 00, 00.
- Back-to-back different symbols (blue=10'h3FF then 10'h000):
  - out_blue = 11 x5 then 00 x5, with no idle cycle between them.
- enable=1, sym_valid=0 for 3 load slots:
  - All data channels serialize 1101010100 three times (pairs 00, 01, 01, 01, 11).
  - uflow_cnt=3.
- uflow_clr asserted in the same cycle as an underflow load: uflow_cnt=1.
- With UFLOW_W=2 and 6 underflows: uflow_cnt saturates at 3.
- enable dropped at phase 1 of a symbol:
  - The symbol finishes (5 pairs total), then the outputs are 00.
  - active=0 and sym_ready stays 0.
- resetn low for 1 cycle at phase 2:
  - The next cycle has outputs 00 and active=0.
  - With enable held high, the first load happens on the following cycle.
